// File: rtl/i2c_slave.sv
// rtl/i2c_slave.sv - I2C target (slave) with synchronised SCL/SDA, 7-bit addressing, byte write/read handshakes
// Optional feature macro: I2C_SLAVE_GEN_CALL_EN (also ACK general-call address 7'h00 with R/W = 0 as a write).
module i2c_slave #(
    parameter int  SYNC_STAGES = 2,
    localparam int DATA_WIDTH  = 8,
    localparam int ADDR_WIDTH  = 7
) (
    input  logic                  clk_i,
    input  logic                  s_rst_i,
    input  logic [ADDR_WIDTH-1:0] self_addr_i,
    input  logic                  scl_i,
    input  logic                  sda_i,
    output logic                  sda_o,
    output logic                  busy_o,
    output logic                  dir_o,
    output logic [DATA_WIDTH-1:0] wr_data_o,
    output logic                  wr_valid_o,
    output logic                  rd_req_o,
    input  logic [DATA_WIDTH-1:0] rd_data_i
);

    // Fewer than two synchroniser flops is never safe, so clamp the depth.
    localparam int STAGES = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        WRITE,
        WRITE_ACK,
        READ,
        READ_ACK,
        IGNORE
    } state_t;

    logic [STAGES-1:0]     scl_sync_q;
    logic [STAGES-1:0]     sda_sync_q;
    logic                  scl_prev_q;
    logic                  sda_prev_q;

    state_t                state_q, state_d;
    logic [2:0]            bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic                  ack_phase_q, ack_phase_d;
    logic                  sda_q, sda_d;
    logic                  busy_q, busy_d;
    logic                  dir_q, dir_d;
    logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
    logic                  wr_valid_q, wr_valid_d;
    logic                  rd_req_q, rd_req_d;

    logic                  scl_s;
    logic                  sda_s;
    logic                  scl_rise;
    logic                  scl_fall;
    logic                  start_det;
    logic                  stop_det;
    logic [DATA_WIDTH-1:0] rx_byte;
    logic                  addr_match;

    // Synchronise the raw bus lines and keep one cycle of history for edge detection.
    always_ff @(posedge clk_i) begin
        if (s_rst_i) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_sync_q <= {scl_sync_q[STAGES-2:0], scl_i};
            sda_sync_q <= {sda_sync_q[STAGES-2:0], sda_i};
            scl_prev_q <= scl_sync_q[STAGES-1];
            sda_prev_q <= sda_sync_q[STAGES-1];
        end
    end

    assign scl_s     = scl_sync_q[STAGES-1];
    assign sda_s     = sda_sync_q[STAGES-1];
    assign scl_rise  = scl_s & ~scl_prev_q;
    assign scl_fall  = ~scl_s & scl_prev_q;
    assign start_det = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
    assign stop_det  = scl_s & scl_prev_q & ~sda_prev_q & sda_s;
    assign rx_byte   = {shift_q[DATA_WIDTH-2:0], sda_s};

`ifdef I2C_SLAVE_GEN_CALL_EN
    assign addr_match = (rx_byte[7:1] == self_addr_i) ||
                        ((rx_byte[7:1] == 7'h00) && !rx_byte[0]);
`else
    assign addr_match = (rx_byte[7:1] == self_addr_i);
`endif

    // State and output registers.
    always_ff @(posedge clk_i) begin
        if (s_rst_i) begin
            state_q     <= IDLE;
            bit_cnt_q   <= 3'd0;
            shift_q     <= '0;
            ack_phase_q <= 1'b0;
            sda_q       <= 1'b1;
            busy_q      <= 1'b0;
            dir_q       <= 1'b0;
            wr_data_q   <= '0;
            wr_valid_q  <= 1'b0;
            rd_req_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            ack_phase_q <= ack_phase_d;
            sda_q       <= sda_d;
            busy_q      <= busy_d;
            dir_q       <= dir_d;
            wr_data_q   <= wr_data_d;
            wr_valid_q  <= wr_valid_d;
            rd_req_q    <= rd_req_d;
        end
    end

    // Next-state logic: STOP and START override every state; otherwise bits move on SCL edges.
    // ack_phase marks the second half of an ACK bit (ACK driven, or controller ACK seen).
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        ack_phase_d = ack_phase_q;
        sda_d       = sda_q;
        busy_d      = busy_q;
        dir_d       = dir_q;
        wr_data_d   = wr_data_q;
        wr_valid_d  = 1'b0;
        rd_req_d    = 1'b0;

        if (stop_det) begin
            state_d     = IDLE;
            sda_d       = 1'b1;
            busy_d      = 1'b0;
            ack_phase_d = 1'b0;
        end else if (start_det) begin
            state_d     = ADDR;
            bit_cnt_d   = 3'd0;
            sda_d       = 1'b1;
            busy_d      = 1'b0;
            ack_phase_d = 1'b0;
        end else begin
            case (state_q)
                ADDR: begin
                    if (scl_rise) begin
                        shift_d = rx_byte;
                        if (bit_cnt_q == 3'd7) begin
                            bit_cnt_d = 3'd0;
                            if (addr_match) begin
                                dir_d       = rx_byte[0];
                                busy_d      = 1'b1;
                                ack_phase_d = 1'b0;
                                state_d     = ADDR_ACK;
                            end else begin
                                state_d = IGNORE;
                            end
                        end else begin
                            bit_cnt_d = bit_cnt_q + 3'd1;
                        end
                    end
                end
                ADDR_ACK: begin
                    if (scl_fall) begin
                        if (!ack_phase_q) begin
                            sda_d       = 1'b0;
                            ack_phase_d = 1'b1;
                        end else begin
                            ack_phase_d = 1'b0;
                            bit_cnt_d   = 3'd0;
                            if (dir_q) begin
                                state_d = READ;
                                shift_d = rd_data_i;
                                sda_d   = rd_data_i[7];
                            end else begin
                                state_d = WRITE;
                                sda_d   = 1'b1;
                            end
                        end
                    end else if (scl_rise && ack_phase_q && dir_q) begin
                        rd_req_d = 1'b1;
                    end
                end
                WRITE: begin
                    if (scl_rise) begin
                        shift_d = rx_byte;
                        if (bit_cnt_q == 3'd7) begin
                            wr_data_d   = rx_byte;
                            wr_valid_d  = 1'b1;
                            bit_cnt_d   = 3'd0;
                            ack_phase_d = 1'b0;
                            state_d     = WRITE_ACK;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 3'd1;
                        end
                    end
                end
                WRITE_ACK: begin
                    if (scl_fall) begin
                        if (!ack_phase_q) begin
                            sda_d       = 1'b0;
                            ack_phase_d = 1'b1;
                        end else begin
                            sda_d       = 1'b1;
                            ack_phase_d = 1'b0;
                            bit_cnt_d   = 3'd0;
                            state_d     = WRITE;
                        end
                    end
                end
                READ: begin
                    if (scl_fall) begin
                        if (bit_cnt_q == 3'd7) begin
                            sda_d       = 1'b1;
                            bit_cnt_d   = 3'd0;
                            ack_phase_d = 1'b0;
                            state_d     = READ_ACK;
                        end else begin
                            sda_d     = shift_q[DATA_WIDTH-2];
                            shift_d   = {shift_q[DATA_WIDTH-2:0], 1'b0};
                            bit_cnt_d = bit_cnt_q + 3'd1;
                        end
                    end
                end
                READ_ACK: begin
                    if (scl_rise && !ack_phase_q) begin
                        if (sda_s) begin
                            state_d = IGNORE;
                            sda_d   = 1'b1;
                            busy_d  = 1'b0;
                        end else begin
                            rd_req_d    = 1'b1;
                            ack_phase_d = 1'b1;
                        end
                    end else if (scl_fall && ack_phase_q) begin
                        ack_phase_d = 1'b0;
                        bit_cnt_d   = 3'd0;
                        shift_d     = rd_data_i;
                        sda_d       = rd_data_i[7];
                        state_d     = READ;
                    end
                end
                default: begin
                    sda_d = 1'b1;
                end
            endcase
        end
    end

    assign sda_o      = sda_q;
    assign busy_o     = busy_q;
    assign dir_o      = dir_q;
    assign wr_data_o  = wr_data_q;
    assign wr_valid_o = wr_valid_q;
    assign rd_req_o   = rd_req_q;

endmodule

// File: tb/tb_i2c_slave.sv
// tb/tb_i2c_slave.sv - scoreboard testbench for i2c_slave driving a modelled open-drain bus
module tb_i2c_slave;

    localparam int Q = 6;
`ifdef I2C_SLAVE_GEN_CALL_EN
    localparam bit GC = 1'b1;
`else
    localparam bit GC = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       s_rst;
    logic [6:0] self_addr;
    logic       ctrl_scl;
    logic       ctrl_sda;
    logic       sda_bus;
    logic       sda_o;
    logic       busy;
    logic       dir;
    logic [7:0] wr_data;
    logic       wr_valid;
    logic       rd_req;
    logic [7:0] rd_data;

    int vectors     = 0;
    int miscompares = 0;
    int wr_cnt      = 0;
    int rd_req_cnt  = 0;

    logic [7:0] exp_wr_q[$];
    logic [7:0] exp_rd_q[$];
    logic [7:0] rd_src_q[$];
    logic [7:0] mon_exp;

    assign sda_bus = ctrl_sda & sda_o;

    i2c_slave #(.SYNC_STAGES(2)) dut (
        .clk_i      (clk),
        .s_rst_i    (s_rst),
        .self_addr_i(self_addr),
        .scl_i      (ctrl_scl),
        .sda_i      (sda_bus),
        .sda_o      (sda_o),
        .busy_o     (busy),
        .dir_o      (dir),
        .wr_data_o  (wr_data),
        .wr_valid_o (wr_valid),
        .rd_req_o   (rd_req),
        .rd_data_i  (rd_data)
    );

    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Write scoreboard and read-data source, sampled away from the active edge.
    always @(negedge clk) begin
        if (wr_valid) begin
            wr_cnt++;
            vectors++;
            if (exp_wr_q.size() == 0) begin
                miscompares++;
                $display("FAIL wr_unexpected: got %02h, no write expected", wr_data);
            end else begin
                mon_exp = exp_wr_q.pop_front();
                if (wr_data !== mon_exp) begin
                    miscompares++;
                    $display("FAIL wr_data: got %02h, expected %02h", wr_data, mon_exp);
                end
            end
        end
        if (rd_req) begin
            rd_req_cnt++;
            if (rd_src_q.size() > 0) rd_data = rd_src_q.pop_front();
        end
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic i2c_start();
        ctrl_sda = 1'b1; wait_clk(Q);
        ctrl_scl = 1'b1; wait_clk(Q);
        ctrl_sda = 1'b0; wait_clk(Q);
        ctrl_scl = 1'b0; wait_clk(Q);
    endtask

    task automatic i2c_stop();
        ctrl_sda = 1'b0; wait_clk(Q);
        ctrl_scl = 1'b1; wait_clk(Q);
        ctrl_sda = 1'b1; wait_clk(Q);
    endtask

    task automatic write_bit(input logic b);
        ctrl_sda = b;    wait_clk(Q);
        ctrl_scl = 1'b1; wait_clk(2 * Q);
        ctrl_scl = 1'b0; wait_clk(Q);
    endtask

    task automatic read_bit(output logic b);
        ctrl_sda = 1'b1; wait_clk(Q);
        ctrl_scl = 1'b1; wait_clk(Q);
        b = sda_bus;     wait_clk(Q);
        ctrl_scl = 1'b0; wait_clk(Q);
    endtask

    task automatic write_byte(input logic [7:0] v, output logic ack);
        for (int i = 7; i >= 0; i--) write_bit(v[i]);
        read_bit(ack);
    endtask

    task automatic read_byte(output logic [7:0] v);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            read_bit(b);
            v[i] = b;
        end
    endtask

    task automatic test_reset();
        s_rst = 1'b1; ctrl_scl = 1'b1; ctrl_sda = 1'b1;
        wait_clk(3);
        vectors += 6;
        if (sda_o !== 1'b1)    begin miscompares++; $display("FAIL rst_sda: got %b, expected 1", sda_o); end
        if (busy !== 1'b0)     begin miscompares++; $display("FAIL rst_busy: got %b, expected 0", busy); end
        if (dir !== 1'b0)      begin miscompares++; $display("FAIL rst_dir: got %b, expected 0", dir); end
        if (wr_data !== 8'h00) begin miscompares++; $display("FAIL rst_wr_data: got %02h, expected 00", wr_data); end
        if (wr_valid !== 1'b0) begin miscompares++; $display("FAIL rst_wr_valid: got %b, expected 0", wr_valid); end
        if (rd_req !== 1'b0)   begin miscompares++; $display("FAIL rst_rd_req: got %b, expected 0", rd_req); end
        s_rst = 1'b0;
        wait_clk(4);
    endtask

    task automatic test_write();
        logic ack;
        int   w0;
        w0 = wr_cnt;
        i2c_start();
        write_byte(8'hA0, ack);
        vectors += 3;
        if (ack !== 1'b0)  begin miscompares++; $display("FAIL wr_addr_ack: got %b, expected 0", ack); end
        if (busy !== 1'b1) begin miscompares++; $display("FAIL wr_busy: got %b, expected 1", busy); end
        if (dir !== 1'b0)  begin miscompares++; $display("FAIL wr_dir: got %b, expected 0", dir); end
        exp_wr_q.push_back(8'h3C);
        write_byte(8'h3C, ack);
        vectors++;
        if (ack !== 1'b0)  begin miscompares++; $display("FAIL wr_data_ack: got %b, expected 0", ack); end
        i2c_stop();
        wait_clk(2);
        vectors += 3;
        if (busy !== 1'b0)     begin miscompares++; $display("FAIL wr_busy_stop: got %b, expected 0", busy); end
        if (sda_o !== 1'b1)    begin miscompares++; $display("FAIL wr_sda_stop: got %b, expected 1", sda_o); end
        if (wr_cnt - w0 !== 1) begin miscompares++; $display("FAIL wr_count: got %0d, expected 1", wr_cnt - w0); end
    endtask

    task automatic test_read();
        logic       ack;
        logic [7:0] v;
        int         r0;
        r0 = rd_req_cnt;
        rd_src_q.push_back(8'h96); exp_rd_q.push_back(8'h96);
        rd_src_q.push_back(8'h5A); exp_rd_q.push_back(8'h5A);
        i2c_start();
        write_byte(8'hA1, ack);
        vectors += 2;
        if (ack !== 1'b0) begin miscompares++; $display("FAIL rd_addr_ack: got %b, expected 0", ack); end
        if (dir !== 1'b1) begin miscompares++; $display("FAIL rd_dir: got %b, expected 1", dir); end
        for (int n = 0; n < 2; n++) begin
            read_byte(v);
            mon_exp = exp_rd_q.pop_front();
            vectors++;
            if (v !== mon_exp) begin miscompares++; $display("FAIL rd_byte%0d: got %02h, expected %02h", n, v, mon_exp); end
            write_bit(n == 1);
        end
        wait_clk(2);
        vectors += 2;
        if (rd_req_cnt - r0 !== 2) begin miscompares++; $display("FAIL rd_req_count: got %0d, expected 2", rd_req_cnt - r0); end
        if (sda_o !== 1'b1)        begin miscompares++; $display("FAIL rd_sda_nack: got %b, expected 1", sda_o); end
        i2c_stop();
    endtask

    task automatic test_mismatch();
        logic ack;
        int   w0;
        w0 = wr_cnt;
        i2c_start();
        write_byte(8'hA2, ack);
        vectors += 2;
        if (ack !== 1'b1)  begin miscompares++; $display("FAIL mm_addr_ack: got %b, expected 1", ack); end
        if (busy !== 1'b0) begin miscompares++; $display("FAIL mm_busy: got %b, expected 0", busy); end
        write_byte(8'h55, ack);
        vectors += 2;
        if (ack !== 1'b1)      begin miscompares++; $display("FAIL mm_data_ack: got %b, expected 1", ack); end
        if (wr_cnt - w0 !== 0) begin miscompares++; $display("FAIL mm_wr_count: got %0d, expected 0", wr_cnt - w0); end
        i2c_stop();
    endtask

    task automatic test_back_to_back();
        logic       ack;
        logic [7:0] v;
        int         r0;
        i2c_start();
        write_byte(8'hA0, ack);
        exp_wr_q.push_back(8'h11);
        write_byte(8'h11, ack);
        vectors += 2;
        if (wr_data !== 8'h11) begin miscompares++; $display("FAIL b2b_wr_data: got %02h, expected 11", wr_data); end
        if (dir !== 1'b0)      begin miscompares++; $display("FAIL b2b_dir0: got %b, expected 0", dir); end
        rd_src_q.push_back(8'hC3); exp_rd_q.push_back(8'hC3);
        r0 = rd_req_cnt;
        i2c_start();
        write_byte(8'hA1, ack);
        vectors += 3;
        if (ack !== 1'b0)          begin miscompares++; $display("FAIL b2b_addr_ack: got %b, expected 0", ack); end
        if (dir !== 1'b1)          begin miscompares++; $display("FAIL b2b_dir1: got %b, expected 1", dir); end
        if (rd_req_cnt - r0 !== 1) begin miscompares++; $display("FAIL b2b_rd_req: got %0d, expected 1", rd_req_cnt - r0); end
        read_byte(v);
        mon_exp = exp_rd_q.pop_front();
        vectors++;
        if (v !== mon_exp) begin miscompares++; $display("FAIL b2b_rd_byte: got %02h, expected %02h", v, mon_exp); end
        write_bit(1'b1);
        i2c_stop();
    endtask

    task automatic test_gen_call();
        logic ack;
        int   w0;
        w0 = wr_cnt;
        i2c_start();
        write_byte(8'h00, ack);
        vectors++;
        if (ack !== !GC) begin miscompares++; $display("FAIL gc_addr_ack: got %b, expected %b", ack, !GC); end
        if (GC) exp_wr_q.push_back(8'h77);
        write_byte(8'h77, ack);
        vectors += 2;
        if (ack !== !GC) begin miscompares++; $display("FAIL gc_data_ack: got %b, expected %b", ack, !GC); end
        if (wr_cnt - w0 !== int'(GC)) begin miscompares++; $display("FAIL gc_wr_count: got %0d, expected %0d", wr_cnt - w0, int'(GC)); end
        i2c_stop();
    endtask

    task automatic test_reset_mid();
        logic       ack;
        logic [7:0] v;
        int         w0;
        v  = 8'hB7;
        w0 = wr_cnt;
        i2c_start();
        write_byte(8'hA0, ack);
        for (int i = 7; i > 4; i--) write_bit(v[i]);
        ctrl_sda = v[4]; wait_clk(Q);
        ctrl_scl = 1'b1; wait_clk(Q);
        s_rst = 1'b1;    wait_clk(1);
        vectors += 2;
        if (sda_o !== 1'b1) begin miscompares++; $display("FAIL rm_sda: got %b, expected 1", sda_o); end
        if (busy !== 1'b0)  begin miscompares++; $display("FAIL rm_busy: got %b, expected 0", busy); end
        s_rst = 1'b0;    wait_clk(Q);
        ctrl_scl = 1'b0; wait_clk(Q);
        for (int i = 3; i >= 0; i--) write_bit(v[i]);
        read_bit(ack);
        vectors += 2;
        if (ack !== 1'b1)      begin miscompares++; $display("FAIL rm_ignored_ack: got %b, expected 1", ack); end
        if (wr_cnt - w0 !== 0) begin miscompares++; $display("FAIL rm_wr_count: got %0d, expected 0", wr_cnt - w0); end
        i2c_stop();
        exp_wr_q.push_back(8'h5E);
        i2c_start();
        write_byte(8'hA0, ack);
        vectors++;
        if (ack !== 1'b0) begin miscompares++; $display("FAIL rm_addr_ack: got %b, expected 0", ack); end
        write_byte(8'h5E, ack);
        vectors += 2;
        if (ack !== 1'b0)      begin miscompares++; $display("FAIL rm_data_ack: got %b, expected 0", ack); end
        if (wr_cnt - w0 !== 1) begin miscompares++; $display("FAIL rm_wr_count2: got %0d, expected 1", wr_cnt - w0); end
        i2c_stop();
    endtask

    initial begin
        s_rst     = 1'b1;
        self_addr = 7'h50;
        ctrl_scl  = 1'b1;
        ctrl_sda  = 1'b1;
        rd_data   = 8'h00;
        test_reset();
        test_write();
        test_read();
        test_mismatch();
        test_back_to_back();
        test_gen_call();
        test_reset_mid();
        wait_clk(4);
        vectors += 2;
        if (exp_wr_q.size() != 0) begin miscompares++; $display("FAIL wr_pending: got %0d, expected 0", exp_wr_q.size()); end
        if (exp_rd_q.size() != 0) begin miscompares++; $display("FAIL rd_pending: got %0d, expected 0", exp_rd_q.size()); end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/i2c_slave.md
I2C_SLAVE -- requirements
Module: i2c_slave

Interface
REQ-001 The module SHALL have parameter SYNC_STAGES, default 2, meaning the number of synchronizer flops on scl_i and sda_i (minimum 2).
REQ-002 The module SHALL have localparams DATA_WIDTH = 8 and ADDR_WIDTH = 7; these are not overridable.
REQ-003 The module SHALL have port clk_i, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 The module SHALL have port s_rst_i, input, 1 bit: reset, synchronous, active-high.
REQ-005 The module SHALL have port self_addr_i, input, 7 bits: own target address, static while busy_o=1.
REQ-006 The module SHALL have port scl_i, input, 1 bit: raw bus SCL; asynchronous to clk_i.
REQ-007 The module SHALL have port sda_i, input, 1 bit: raw bus SDA; asynchronous to clk_i.
REQ-008 The module SHALL have port sda_o, output, 1 bit: 0 = pull SDA low, 1 = release.
REQ-009 The module SHALL have port busy_o, output, 1 bit: addressed transaction in progress.
REQ-010 The module SHALL have port dir_o, output, 1 bit: R/W bit of the current transaction (1 = controller read).
REQ-011 The module SHALL have port wr_data_o, output, 8 bits: last byte received from the controller.
REQ-012 The module SHALL have port wr_valid_o, output, 1 bit: 1-cycle pulse, wr_data_o is new.
REQ-013 The module SHALL have port rd_req_o, output, 1 bit: 1-cycle pulse, user must present the next read byte.
REQ-014 The module SHALL have port rd_data_i, input, 8 bits: byte to transmit to the controller.

Function
REQ-015 scl_i and sda_i SHALL each pass through SYNC_STAGES flops; edges are detected by comparing each synchronized signal with its value one cycle earlier.
REQ-016 A START (synchronized SDA falls while synchronized SCL = 1) SHALL move the FSM to ADDR from any state, including repeated START mid-transfer.
REQ-017 A STOP (synchronized SDA rises while synchronized SCL = 1) SHALL move the FSM to IDLE from any state and SHALL set sda_o = 1 and busy_o = 0 in the next cycle.
REQ-018 The FSM states SHALL be IDLE, ADDR, ADDR_ACK, WRITE, WRITE_ACK, READ, READ_ACK and IGNORE.
REQ-019 The module SHALL sample SDA on each SCL rising edge and SHALL change sda_o only on SCL falling edges.
REQ-020 ADDR: after 8 bits are shifted in MSB first, a 7-bit match with self_addr_i SHALL latch dir_o, set busy_o = 1, and go to ADDR_ACK; a mismatch SHALL go to IGNORE.
REQ-021 ADDR_ACK: sda_o SHALL be 0 from the next SCL falling edge until the following SCL falling edge; then the FSM SHALL go to WRITE if dir_o = 0, or READ if dir_o = 1.
REQ-022 WRITE: on the 8th SCL rising edge, wr_data_o SHALL be updated and wr_valid_o SHALL pulse in the same cycle; then WRITE_ACK drives ACK (sda_o = 0) for one SCL bit and returns to WRITE.
REQ-023 rd_req_o SHALL pulse on the SCL rising edge of the address-ACK bit when dir_o = 1, and on the SCL rising edge of each READ_ACK bit that the controller ACKs.
REQ-024 rd_data_i SHALL be captured on the SCL falling edge that ends the ACK bit; bit 7 is output first and each following bit is shifted on each SCL falling edge.
REQ-025 READ_ACK: sda_o SHALL be released; SDA is sampled on the SCL rising edge; 0 (ACK) SHALL go to READ; 1 (NACK) SHALL go to IGNORE with sda_o = 1 and no rd_req_o.
REQ-026 IGNORE SHALL keep sda_o = 1 and all pulses at 0 until START or STOP.
REQ-027 The bit counter SHALL be 3 bits, SHALL clear on START and at the entry of each byte, and SHALL never wrap within a byte.
REQ-028 START/STOP detection latency SHALL be SYNC_STAGES+1 clk_i cycles after the pin change.
REQ-029 The module SHALL NOT stretch SCL.

Reset
REQ-030 While s_rst_i = 1, at the next clock edge the FSM SHALL go to IDLE with sda_o = 1, busy_o = 0, dir_o = 0, wr_data_o = 0, wr_valid_o = 0, rd_req_o = 0 and synchronizers = 1.
REQ-031 A reset mid-transfer SHALL release SDA immediately; the block SHALL then ignore the bus until the next START.

Configuration
REQ-032 With macro I2C_SLAVE_GEN_CALL_EN defined, address 7'h00 with R/W = 0 SHALL also be ACKed and handled as a write.
REQ-033 With I2C_SLAVE_GEN_CALL_EN undefined, 7'h00 SHALL be treated as a mismatch unless self_addr_i = 7'h00.

Verification
REQ-034 self_addr_i = 7'h50; controller writes 0xA0, 0x3C, STOP -> address ACK, one wr_valid_o with wr_data_o = 0x3C, data ACK, busy_o = 0 after STOP.
REQ-035 self_addr_i = 7'h50; controller sends 0xA1, rd_data_i = 0x96 then 0x5A, controller sends ACK then NACK -> SDA carries 0x96 then 0x5A, two rd_req_o pulses, then IGNORE.
REQ-036 Controller sends 0xA2 to self_addr_i = 7'h50 -> no ACK (sda_o stays 1), busy_o stays 0, no wr_valid_o.
REQ-037 Write 0xA0, 0x11, repeated START, 0xA1 read -> wr_data_o = 0x11, dir_o changes to 1, rd_req_o pulses at the second address ACK.
REQ-038 Controller sends 0x00, 0x77 -> with I2C_SLAVE_GEN_CALL_EN: ACK and wr_data_o = 0x77; without it: NACK and no wr_valid_o.
REQ-039 Assert s_rst_i during bit 4 of a write byte -> sda_o = 1 next cycle, no wr_valid_o, and the next addressed write completes normally.
